// File: rtl/conway_pkg.sv
// Shared types and seed pattern for the Life generation store.
// Seed rows are defined as 16-bit constants, adapted to other row widths by seed_row().
package conway_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SWAP = 2'd2
    } state_e;

    localparam int SEED_ROWS = 4;
    localparam int SEED_W    = 16;
    localparam int MAX_ROW_W = 64;

    // Low row_w bits of the 16-bit seed row k, zero-extended; rows past the table are empty.
    function automatic logic [MAX_ROW_W-1:0] seed_row(input int k, input int row_w);
        logic [SEED_W-1:0]    s;
        logic [MAX_ROW_W-1:0] r;
        case (k)
            0:       s = 16'h0700;
            1:       s = 16'h3300;
            2:       s = 16'h33CC;
            3:       s = 16'h6186;
            default: s = 16'h0000;
        endcase
        r = '0;
        for (int i = 0; i < SEED_W; i++) begin
            if (i < row_w) begin
                r[i] = s[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conway_row_bank.sv
// One bank of grid rows: a single write port and two registered read ports.
// Out-of-range reads return zero and out-of-range writes are dropped.
module conway_row_bank #(
    parameter int ROW_W  = 16,
    parameter int ROWS   = 4,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [ROW_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [ROW_W-1:0]  rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [ROW_W-1:0]  rdata_b_o
);

    localparam bit FULL_MAP = (ROWS == (1 << ADDR_W));

    logic [ROW_W-1:0] mem_q [ROWS];
    logic [ROW_W-1:0] rdata_a_q;
    logic [ROW_W-1:0] rdata_b_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return FULL_MAP || (int'(addr) < ROWS);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (we_i && in_range(waddr_i)) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_a_q <= in_range(raddr_a_i) ? mem_q[raddr_a_i] : '0;
            rdata_b_q <= in_range(raddr_b_i) ? mem_q[raddr_b_i] : '0;
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/conway_gen_mem.sv
// Double-buffered Life generation store: current bank feeds the VGA and selector reads,
// next bank takes selector writes, swap flips them; a sequencer seeds both banks.
module conway_gen_mem
    import conway_pkg::*;
#(
    parameter int ROW_W  = 16,
    parameter int ROWS   = 4,
    parameter int ADDR_W = $clog2(ROWS),
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_load,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ROW_W-1:0]  vga_row,
    input  logic [ADDR_W-1:0] sel_addr,
    output logic [ROW_W-1:0]  sel_row,
    input  logic              write_enb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              busy,
    output logic [GEN_W-1:0]  gen_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic              bank_sel_q, bank_sel_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic              ack_q, ack_d;
    logic              pend_q, pend_d;
    logic              rd_sel_q;

    logic              load_we;
    logic              user_we;
    logic [1:0]        bank_we;
    logic [ADDR_W-1:0] bk_waddr;
    logic [ROW_W-1:0]  bk_wdata;
    logic [ROW_W-1:0]  load_dat;
    logic [MAX_ROW_W-1:0] seed_full;
    logic              unused_seed_hi;
    logic [ROW_W-1:0]  vga_row0, vga_row1, sel_row0, sel_row1;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        bank_sel_d = bank_sel_q;
        gen_d      = gen_q;
        ack_d      = 1'b0;
        pend_d     = pend_q;
        load_we    = 1'b0;
        user_we    = 1'b0;
        case (state_q)
            IDLE: begin
                user_we = write_enb;
                if (debug_load) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end else if (swap_req || pend_q) begin
                    state_d = SWAP;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                load_we = 1'b1;
                if (swap_req) begin
                    pend_d = 1'b1;
                end
                if (load_cnt_q == ADDR_W'(ROWS - 1)) begin
                    state_d    = IDLE;
                    load_cnt_d = '0;
                    gen_d      = '0;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            SWAP: begin
                user_we    = write_enb;
                state_d    = IDLE;
                bank_sel_d = ~bank_sel_q;
                ack_d      = 1'b1;
                gen_d      = gen_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            bank_sel_q <= 1'b0;
            gen_q      <= '0;
            ack_q      <= 1'b0;
            pend_q     <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            bank_sel_q <= bank_sel_d;
            gen_q      <= gen_d;
            ack_q      <= ack_d;
            pend_q     <= pend_d;
            rd_sel_q   <= bank_sel_q;
        end
    end

    assign seed_full      = seed_row(int'(load_cnt_q), ROW_W);
    assign load_dat       = seed_full[ROW_W-1:0];
    assign unused_seed_hi = ^seed_full[MAX_ROW_W-1:ROW_W];

    // Seed goes to both banks; user writes only reach the bank that is currently "next".
    assign bk_waddr   = load_we ? load_cnt_q : wr_addr;
    assign bk_wdata   = load_we ? load_dat : wr_row;
    assign bank_we[0] = load_we | (user_we & bank_sel_q);
    assign bank_we[1] = load_we | (user_we & ~bank_sel_q);

    conway_row_bank #(.ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .we_i      (bank_we[0]),
        .waddr_i   (bk_waddr),
        .wdata_i   (bk_wdata),
        .raddr_a_i (vga_addr),
        .rdata_a_o (vga_row0),
        .raddr_b_i (sel_addr),
        .rdata_b_o (sel_row0)
    );

    conway_row_bank #(.ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .we_i      (bank_we[1]),
        .waddr_i   (bk_waddr),
        .wdata_i   (bk_wdata),
        .raddr_a_i (vga_addr),
        .rdata_a_o (vga_row1),
        .raddr_b_i (sel_addr),
        .rdata_b_o (sel_row1)
    );

    // rd_sel_q remembers which bank was current when the read address was sampled.
    assign vga_row   = rd_sel_q ? vga_row1 : vga_row0;
    assign sel_row   = rd_sel_q ? sel_row1 : sel_row0;
    assign swap_ack  = ack_q;
    assign busy      = (state_q != IDLE);
    assign gen_count = gen_q;

endmodule

// File: tb/tb_conway_gen_mem.sv
// Directed bench for conway_gen_mem: default build plus GEN_W=2 and ROWS=6/ROW_W=8 builds.
module tb_conway_gen_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        debug_load = 1'b0;
    logic [1:0]  vga_addr = '0, sel_addr = '0, wr_addr = '0;
    logic [15:0] wr_row = '0;
    logic        write_enb = 1'b0;
    logic        swap_req = 1'b0;

    logic [15:0] vga_row, sel_row;
    logic        swap_ack, busy;
    logic [15:0] gen_count;

    logic [15:0] w_vga_row, w_sel_row;
    logic        w_swap_ack, w_busy;
    logic [1:0]  w_gen_count;

    logic [2:0]  r_vga_addr = '0, r_sel_addr = '0;
    logic [7:0]  r_vga_row, r_sel_row;
    logic        r_swap_ack, r_busy;
    logic [15:0] r_gen_count;

    int checks = 0;
    int errors = 0;
    int n;

    logic [15:0] seed  [4] = '{16'h0700, 16'h3300, 16'h33CC, 16'h6186};
    logic [15:0] row_e [4];
    logic [7:0]  rexp  [6] = '{8'h00, 8'h00, 8'hCC, 8'h86, 8'h00, 8'h00};
    logic [1:0]  wexp  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    always #5 clk = ~clk;

    conway_gen_mem dut (
        .clk(clk), .rst(rst), .debug_load(debug_load),
        .vga_addr(vga_addr), .vga_row(vga_row), .sel_addr(sel_addr), .sel_row(sel_row),
        .write_enb(write_enb), .wr_addr(wr_addr), .wr_row(wr_row),
        .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy), .gen_count(gen_count)
    );

    conway_gen_mem #(.GEN_W(2)) dut_w (
        .clk(clk), .rst(rst), .debug_load(debug_load),
        .vga_addr(vga_addr), .vga_row(w_vga_row), .sel_addr(sel_addr), .sel_row(w_sel_row),
        .write_enb(write_enb), .wr_addr(wr_addr), .wr_row(wr_row),
        .swap_req(swap_req), .swap_ack(w_swap_ack), .busy(w_busy), .gen_count(w_gen_count)
    );

    conway_gen_mem #(.ROWS(6), .ROW_W(8)) dut_r (
        .clk(clk), .rst(rst), .debug_load(debug_load),
        .vga_addr(r_vga_addr), .vga_row(r_vga_row), .sel_addr(r_sel_addr), .sel_row(r_sel_row),
        .write_enb(1'b0), .wr_addr(3'd0), .wr_row(8'h00),
        .swap_req(1'b0), .swap_ack(r_swap_ack), .busy(r_busy), .gen_count(r_gen_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_vga", vga_row, 0);
        check("rst_sel", sel_row, 0);
        check("rst_ack", swap_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_gen", gen_count, 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a load, at load row 2
        debug_load = 1'b1;
        tick();
        debug_load = 1'b0;
        check("midload_busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midload_rst_busy", busy, 0);
        vga_addr = 2'd0;
        sel_addr = 2'd1;
        tick();
        check("midload_vga0", vga_row, 0);
        check("midload_sel1", sel_row, 0);
        check("midload_gen", gen_count, 0);
        rst = 1'b0;
        tick();

        // Seed load: busy for exactly four cycles
        debug_load = 1'b1;
        tick();
        debug_load = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            n++;
            tick();
        end
        check("load_busy_cycles", n, 4);
        for (int k = 0; k < 4; k++) begin
            sel_addr = 2'(k);
            vga_addr = 2'(3 - k);
            tick();
            check("seed_sel", sel_row, seed[k]);
            check("seed_vga", vga_row, seed[3-k]);
        end

        // Fill the next bank; reads keep showing the seed
        for (int k = 0; k < 4; k++) begin
            write_enb = 1'b1;
            wr_addr   = 2'(k);
            wr_row    = 16'(k + 1);
            sel_addr  = 2'(k);
            tick();
            check("wr_hidden", sel_row, seed[k]);
        end
        write_enb = 1'b0;

        // First swap
        swap_req = 1'b1;
        tick();
        check("swap1_busy", busy, 1);
        check("swap1_noack", swap_ack, 0);
        tick();
        check("swap1_ack", swap_ack, 1);
        check("swap1_gen", gen_count, 1);
        swap_req = 1'b0;
        tick();
        check("swap1_ack_drop", swap_ack, 0);
        for (int k = 0; k < 4; k++) begin
            sel_addr = 2'(k);
            vga_addr = 2'(3 - k);
            tick();
            check("swap1_sel", sel_row, 16'(k + 1));
            check("swap1_vga", vga_row, 16'(4 - k));
        end

        // Second swap, with a write and a read issued in the SWAP cycle
        swap_req = 1'b1;
        tick();
        write_enb = 1'b1;
        wr_addr   = 2'd0;
        wr_row    = 16'h00AA;
        sel_addr  = 2'd1;
        tick();
        write_enb = 1'b0;
        swap_req  = 1'b0;
        check("swap2_ack", swap_ack, 1);
        check("swap2_gen", gen_count, 2);
        check("swap2_read_old", sel_row, 16'h0002);
        row_e[0] = 16'h00AA;
        row_e[1] = seed[1];
        row_e[2] = seed[2];
        row_e[3] = seed[3];
        for (int k = 0; k < 4; k++) begin
            sel_addr = 2'(k);
            vga_addr = 2'(3 - k);
            tick();
            check("swap2_sel", sel_row, row_e[k]);
            check("swap2_vga", vga_row, row_e[3-k]);
        end

        // debug_load and swap_req together: load first, then one swap; writes in LOAD dropped
        debug_load = 1'b1;
        swap_req   = 1'b1;
        tick();
        debug_load = 1'b0;
        check("col_load_busy", busy, 1);
        write_enb = 1'b1;
        wr_addr   = 2'd1;
        wr_row    = 16'hFFFF;
        repeat (4) tick();
        write_enb = 1'b0;
        check("col_idle", busy, 0);
        check("col_gen_cleared", gen_count, 0);
        tick();
        check("col_swap_busy", busy, 1);
        tick();
        check("col_ack", swap_ack, 1);
        swap_req = 1'b0;
        check("col_gen", gen_count, 1);
        sel_addr = 2'd1;
        vga_addr = 2'd0;
        tick();
        check("col_no_load_write", sel_row, 16'h3300);
        check("col_row0_reseeded", vga_row, 16'h0700);

        // Reload then five swaps: GEN_W=2 build wraps
        debug_load = 1'b1;
        tick();
        debug_load = 1'b0;
        repeat (4) tick();
        check("wrap_gen0", gen_count, 0);
        for (int s = 0; s < 5; s++) begin
            swap_req = 1'b1;
            tick();
            tick();
            check("wrap_ack", swap_ack, 1);
            swap_req = 1'b0;
            check("wrap_gen_w2", w_gen_count, wexp[s]);
            check("wrap_gen_w16", gen_count, 16'(s + 1));
            tick();
        end

        // ROWS=6, ROW_W=8 build seed contents and out-of-range read
        check("r6_idle", r_busy, 0);
        for (int k = 0; k < 6; k++) begin
            r_sel_addr = 3'(k);
            r_vga_addr = 3'd7;
            tick();
            check("r6_seed", r_sel_row, rexp[k]);
            check("r6_oob", r_vga_row, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
